// File: rtl/alu_result_bcd_display.sv
// Display stage for the registered ALU result: iterative double-dabble binary
// to BCD, one bit per cycle, with held active-low 7-segment digit codes.
module alu_result_bcd_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  input  logic                  blank_zeros,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_next;
  logic [CW-1:0]    cnt;
  logic             lead;

  assign in_ready = (state == IDLE);
  assign busy     = (state == SHIFT) || (state == DONE);

  // Add-3 correction on every digit, then shift in the next binary MSB.
  always_comb begin
    adj = scratch;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
    end
    scratch_next = (adj << 1) | BW'(bin[WIDTH-1]);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      bin       <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin     <= in_data;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          bin     <= bin << 1;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd       <= scratch_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  // Walk from the most significant digit down; lead stays set while every
  // digit seen so far is zero, so those digits can be blanked.
  always_comb begin
    seg  = '1;
    lead = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      lead = lead & (bcd[4*(DIGITS-1-i) +: 4] == 4'd0);
      if (blank_zeros && lead && (i != DIGITS - 1)) begin
        seg[7*(DIGITS-1-i) +: 7] = 7'b1111111;
      end else begin
        seg[7*(DIGITS-1-i) +: 7] = seg7(bcd[4*(DIGITS-1-i) +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_bcd_display.sv
// Directed self-checking bench for alu_result_bcd_display (WIDTH=8, DIGITS=3).
module tb_alu_result_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        blank_zeros;
  logic        busy;
  logic        out_valid;
  logic [11:0] bcd;
  logic [20:0] seg;

  int          passed = 0;
  int          total  = 0;
  int          pulses;
  int          lat;
  int          acc;
  int          pk1, pk2;
  logic        drop;
  logic [11:0] pbcd, pbcd2, mid_bcd;
  logic [20:0] pseg;

  alu_result_bcd_display #(.WIDTH(8), .DIGITS(3)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .blank_zeros (blank_zeros),
    .busy        (busy),
    .out_valid   (out_valid),
    .bcd         (bcd),
    .seg         (seg)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept one value, optionally pulse in_valid with inj_v at sample point
  // inj_k, and watch 14 cycles for result pulses.
  task automatic run(input logic [7:0] v, input int inj_k, input logic [7:0] inj_v);
    in_data  = v;
    in_valid = 1'b1;
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    pulses   = 0;
    lat      = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == inj_k + 1) in_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (lat == 0) begin
          lat  = k + 1;
          pbcd = bcd;
          pseg = seg;
        end
      end
      if (k == 4) mid_bcd = bcd;
      if (k == 1) check("busy_in_shift", {30'd0, busy, in_ready}, 32'd2);
      if (k == 8) check("busy_in_done", {30'd0, busy, in_ready}, 32'd2);
      if (k == 9) check("idle_after_done", {30'd0, busy, in_ready}, 32'd1);
      if (k == inj_k) begin
        in_valid = 1'b1;
        in_data  = inj_v;
      end
    end
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    blank_zeros = 1'b0;
    step();
    step();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy_valid", {30'd0, busy, out_valid}, 32'd0);
    check("rst_bcd", {20'd0, bcd}, 32'h000);
    check("rst_seg_noblank", {11'd0, seg}, {11'd0, S0, S0, S0});
    blank_zeros = 1'b1;
    #1;
    check("rst_seg_blank", {11'd0, seg}, {11'd0, BL, BL, S0});
    resetn = 1'b1;
    blank_zeros = 1'b0;
    step();

    // T1: full-scale value
    run(8'd255, -10, 8'd0);
    check("t1_pulses", pulses, 1);
    check("t1_latency", lat, 9);
    check("t1_bcd", {20'd0, pbcd}, 32'h255);
    check("t1_seg", {11'd0, pseg}, {11'd0, S2, S5, S5});
    check("t1_held_mid", {20'd0, mid_bcd}, 32'h000);

    // T2: zero with blanking, then blanking off without a clock edge
    blank_zeros = 1'b1;
    run(8'd0, -10, 8'd0);
    check("t2_pulses", pulses, 1);
    check("t2_bcd", {20'd0, pbcd}, 32'h000);
    check("t2_seg_blank", {11'd0, pseg}, {11'd0, BL, BL, S0});
    check("t2_held_mid", {20'd0, mid_bcd}, 32'h255);
    blank_zeros = 1'b0;
    #1;
    check("t2_seg_noblank", {11'd0, seg}, {11'd0, S0, S0, S0});

    // T3: 100 then 9 held valid until in_ready returns
    blank_zeros = 1'b1;
    in_data  = 8'd100;
    in_valid = 1'b1;
    check("t3_accept_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_data = 8'd9;
    pulses = 0; acc = 0; drop = 1'b0; pk1 = 0; pk2 = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (drop) begin
        in_valid = 1'b0;
        drop     = 1'b0;
      end
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin pk1 = k; pbcd = bcd; pseg = seg; end
        if (pulses == 2) begin pk2 = k; pbcd2 = bcd; end
      end
      if (in_valid && in_ready && acc == 0) begin
        acc  = k;
        drop = 1'b1;
      end
    end
    check("t3_pulses", pulses, 2);
    check("t3_ready_return", acc, 9);
    check("t3_pulse1_time", pk1, 8);
    check("t3_bcd1", {20'd0, pbcd}, 32'h100);
    check("t3_seg1_blank", {11'd0, pseg}, {11'd0, S1, S0, S0});
    check("t3_pulse2_time", pk2, 18);
    check("t3_bcd2", {20'd0, pbcd2}, 32'h009);
    check("t3_seg2_blank", {11'd0, seg}, {11'd0, BL, BL, S9});
    blank_zeros = 1'b0;
    #1;
    check("t3_seg2_noblank", {11'd0, seg}, {11'd0, S0, S0, S9});

    // T4: in_valid pulse during SHIFT is dropped
    blank_zeros = 1'b1;
    run(8'd77, 2, 8'd42);
    check("t4_pulses", pulses, 1);
    check("t4_latency", lat, 9);
    check("t4_bcd", {20'd0, pbcd}, 32'h077);
    check("t4_held_mid", {20'd0, mid_bcd}, 32'h009);
    check("t4_bcd_after", {20'd0, bcd}, 32'h077);
    check("t4_seg", {11'd0, seg}, {11'd0, BL, S7, S7});
    blank_zeros = 1'b0;

    // T5: reset during the 4th SHIFT cycle of 200
    in_data  = 8'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    resetn = 1'b0;
    step();
    check("t5_ready", {31'd0, in_ready}, 32'd1);
    check("t5_busy_valid", {30'd0, busy, out_valid}, 32'd0);
    check("t5_bcd", {20'd0, bcd}, 32'h000);
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) pulses++;
    end
    check("t5_no_pulse", pulses, 0);
    check("t5_bcd_held", {20'd0, bcd}, 32'h000);
    run(8'd7, -10, 8'd0);
    check("t5_next_bcd", {20'd0, pbcd}, 32'h007);
    check("t5_next_latency", lat, 9);

    // T6: exhaustive sweep against a decimal model
    for (int v = 0; v < 256; v++) begin
      run(v[7:0], -10, 8'd0);
      check("sweep_bcd", {20'd0, pbcd},
            {20'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
      check("sweep_latency", lat, 9);
      check("sweep_pulses", pulses, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
